// File: rtl/voq_egress_scheduler_if.sv
// Stream bundle between one egress scheduler and the fabric queue read side / egress pins.
// The master side is the scheduler. The slave side is the queue plus the downstream consumer.
interface voq_egress_scheduler_if #(
  parameter int PORT_NUB_TOTAL = 4,
  parameter int DATA_WIDTH     = 16
) ();
  localparam int WIDTH_SEL = $clog2(PORT_NUB_TOTAL);

  logic [PORT_NUB_TOTAL-1:0] empty;
  logic [DATA_WIDTH-1:0]     data_in;
  logic                      data_eop_in;
  logic                      qos_mode;
  logic                      ready;
  logic                      rd_en;
  logic [WIDTH_SEL-1:0]      rd_sel;
  logic                      rd_sop;
  logic                      rd_eop;
  logic                      rd_vld;
  logic [DATA_WIDTH-1:0]     rd_data;
  logic                      busy;
  logic                      error;

  modport master (
    input  empty, data_in, data_eop_in, qos_mode, ready,
    output rd_en, rd_sel, rd_sop, rd_eop, rd_vld, rd_data, busy, error
  );

  modport slave (
    output empty, data_in, data_eop_in, qos_mode, ready,
    input  rd_en, rd_sel, rd_sop, rd_eop, rd_vld, rd_data, busy, error
  );
endinterface

// File: rtl/voq_egress_scheduler.sv
// Per-egress-port VOQ scheduler: arbitrates round-robin or strict priority between ingress queues,
// then drains the granted queue one whole packet at a time, aborting on a prolonged mid-packet underrun.
module voq_egress_scheduler #(
  parameter int PORT_NUB_TOTAL = 4,
  parameter int DATA_WIDTH     = 16,
  parameter int STALL_MAX      = 255
) (
  input  logic                   clk,
  input  logic                   rst,
  voq_egress_scheduler_if.master bus
);
  localparam int WIDTH_SEL = $clog2(PORT_NUB_TOTAL);
  localparam int CNT_W     = $clog2(STALL_MAX + 1);
  localparam logic [CNT_W-1:0]     STALL_LAST = CNT_W'(STALL_MAX - 1);
  localparam logic [WIDTH_SEL:0]   PORTS_W    = (WIDTH_SEL + 1)'(PORT_NUB_TOTAL);
  localparam logic [WIDTH_SEL-1:0] LAST_PORT  = WIDTH_SEL'(PORT_NUB_TOTAL - 1);

  typedef enum logic [0:0] {IDLE = 1'b0, XFER = 1'b1} state_t;

  state_t                state_r;
  state_t                state_nxt_s;
  logic [WIDTH_SEL-1:0]  grant_r;
  logic [WIDTH_SEL-1:0]  rr_ptr_r;
  logic [CNT_W-1:0]      stall_cnt_r;
  logic                  first_word_r;
  logic                  mode_r;
  logic                  rd_vld_r;
  logic                  rd_sop_r;
  logic                  rd_eop_r;
  logic [DATA_WIDTH-1:0] rd_data_r;
  logic                  error_r;

  logic [WIDTH_SEL-1:0]  base_s;
  logic [WIDTH_SEL:0]    sum_s;
  logic [WIDTH_SEL-1:0]  pick_s;
  logic                  found_s;
  logic                  hit_s;
  logic                  rd_en_s;
  logic                  stall_s;
  logic                  abort_s;

  function automatic logic [WIDTH_SEL-1:0] next_port(input logic [WIDTH_SEL-1:0] p);
    return (p == LAST_PORT) ? '0 : p + WIDTH_SEL'(1);
  endfunction

  // Arbiter: scan from base (0 for strict, rr_ptr for round-robin) and take the first pending VOQ.
  always_comb begin
    base_s  = bus.qos_mode ? '0 : rr_ptr_r;
    pick_s  = '0;
    found_s = 1'b0;
    sum_s   = '0;
    hit_s   = 1'b0;
    for (int k = 0; k < PORT_NUB_TOTAL; k++) begin
      sum_s   = {1'b0, base_s} + (WIDTH_SEL + 1)'(k);
      sum_s   = (sum_s >= PORTS_W) ? (sum_s - PORTS_W) : sum_s;
      hit_s   = !found_s && !bus.empty[sum_s[WIDTH_SEL-1:0]];
      pick_s  = hit_s ? sum_s[WIDTH_SEL-1:0] : pick_s;
      found_s = found_s | hit_s;
    end
  end

  // Next-state and pop/stall decode.
  always_comb begin
    state_nxt_s = state_r;
    rd_en_s     = 1'b0;
    stall_s     = 1'b0;
    abort_s     = 1'b0;
    case (state_r)
      IDLE: begin
        if (found_s) begin
          state_nxt_s = XFER;
        end else begin
          state_nxt_s = IDLE;
        end
      end
      XFER: begin
        rd_en_s = bus.ready & ~bus.empty[grant_r];
        stall_s = bus.ready & bus.empty[grant_r];
        abort_s = stall_s & (stall_cnt_r == STALL_LAST);
        if ((rd_en_s & bus.data_eop_in) | abort_s) begin
          state_nxt_s = IDLE;
        end else begin
          state_nxt_s = XFER;
        end
      end
      default: state_nxt_s = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Grant, round-robin pointer, stall counter and the registered egress word.
  always_ff @(posedge clk) begin
    if (rst) begin
      grant_r      <= '0;
      rr_ptr_r     <= '0;
      stall_cnt_r  <= '0;
      first_word_r <= 1'b0;
      mode_r       <= 1'b0;
      rd_vld_r     <= 1'b0;
      rd_sop_r     <= 1'b0;
      rd_eop_r     <= 1'b0;
      rd_data_r    <= '0;
      error_r      <= 1'b0;
    end else begin
      rd_vld_r  <= rd_en_s;
      rd_sop_r  <= rd_en_s & first_word_r;
      rd_eop_r  <= rd_en_s & bus.data_eop_in;
      rd_data_r <= rd_en_s ? bus.data_in : rd_data_r;
      error_r   <= abort_s;
      case (state_r)
        IDLE: begin
          stall_cnt_r <= '0;
          if (found_s) begin
            grant_r      <= pick_s;
            first_word_r <= 1'b1;
            mode_r       <= bus.qos_mode;
          end
        end
        XFER: begin
          // Backpressure (ready low) leaves the stall counter untouched.
          if (rd_en_s) begin
            first_word_r <= 1'b0;
            stall_cnt_r  <= '0;
            if (bus.data_eop_in && !mode_r) begin
              rr_ptr_r <= next_port(grant_r);
            end
          end else if (abort_s) begin
            stall_cnt_r <= '0;
            if (!mode_r) begin
              rr_ptr_r <= next_port(grant_r);
            end
          end else if (stall_s) begin
            stall_cnt_r <= stall_cnt_r + CNT_W'(1);
          end
        end
        default: stall_cnt_r <= '0;
      endcase
    end
  end

  // A pop requested while reset is asserted would be lost by the queue, so gate it.
  assign bus.rd_en   = rd_en_s & ~rst;
  assign bus.rd_sel  = grant_r;
  assign bus.rd_sop  = rd_sop_r;
  assign bus.rd_eop  = rd_eop_r;
  assign bus.rd_vld  = rd_vld_r;
  assign bus.rd_data = rd_data_r;
  assign bus.busy    = (state_r == XFER);
  assign bus.error   = error_r;
endmodule

// File: tb/tb_voq_egress_scheduler.sv
// Scoreboard bench: a VOQ model feeds the scheduler; every pop pushes the expected egress word,
// which is popped and compared one cycle later. Expected grant order is queued per scenario.
module tb_voq_egress_scheduler;
  localparam int N  = 4;
  localparam int DW = 16;

  typedef struct packed {
    logic          sop;
    logic          eop;
    logic [DW-1:0] data;
  } word_t;

  logic clk = 1'b0;
  logic rst = 1'b1;

  voq_egress_scheduler_if #(.PORT_NUB_TOTAL(N), .DATA_WIDTH(DW)) bus ();

  voq_egress_scheduler #(.PORT_NUB_TOTAL(N), .DATA_WIDTH(DW), .STALL_MAX(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  word_t         voq [N][$];
  word_t         exp_q[$];
  int            ord_q[$];
  int            errors  = 0;
  int            checks  = 0;
  int            cyc     = 0;
  int            vld_cnt = 0;
  int            eop_cnt = 0;
  int            err_cnt = 0;
  int            pkt_id  = 0;
  logic          pop_en;
  logic          busy_pre;
  logic [1:0]    pop_sel;
  logic [DW-1:0] last_data = 16'h0;

  task automatic load_pkt(input int v, input int n, input bit with_eop);
    word_t w;
    for (int i = 0; i < n; i++) begin
      w.sop  = (i == 0);
      w.eop  = with_eop && (i == n - 1);
      w.data = 16'(v * 4096 + (pkt_id % 16) * 256 + i);
      voq[v].push_back(w);
    end
    pkt_id++;
  endtask

  task automatic drive_inputs();
    int sel;
    for (int i = 0; i < N; i++) bus.empty[i] = (voq[i].size() == 0);
    sel = int'(bus.rd_sel);
    if (voq[sel].size() > 0) begin
      bus.data_in     = voq[sel][0].data;
      bus.data_eop_in = voq[sel][0].eop;
    end else begin
      bus.data_in     = 16'h0;
      bus.data_eop_in = 1'b0;
    end
  endtask

  // One clock: drive at negedge, sample rd_en just before posedge, model the pop, check at next negedge.
  task automatic cycle();
    word_t w;
    int    s;
    int    exp_id;
    drive_inputs();
    #4;
    pop_en   = bus.rd_en;
    pop_sel  = bus.rd_sel;
    busy_pre = bus.busy;
    @(posedge clk);
    if (pop_en === 1'b1) begin
      s = int'(pop_sel);
      checks++;
      if (voq[s].size() == 0) begin
        errors++;
        $display("FAIL pop_from_empty voq=%0d", s);
      end else begin
        w = voq[s].pop_front();
        exp_q.push_back(w);
        if (w.sop) begin
          exp_id = (ord_q.size() > 0) ? ord_q.pop_front() : -1;
          if (s !== exp_id) begin
            errors++;
            $display("FAIL grant_order got=%0d exp=%0d", s, exp_id);
          end
        end
      end
    end
    @(negedge clk);
    cyc++;
    checks++;
    if (bus.rd_vld === 1'b1) begin
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_word data=%h", bus.rd_data);
      end else begin
        w = exp_q.pop_front();
        if ({bus.rd_sop, bus.rd_eop, bus.rd_data} !== {w.sop, w.eop, w.data}) begin
          errors++;
          $display("FAIL egress_word got sop=%b eop=%b data=%h exp sop=%b eop=%b data=%h",
                   bus.rd_sop, bus.rd_eop, bus.rd_data, w.sop, w.eop, w.data);
        end
      end
      last_data = bus.rd_data;
      vld_cnt++;
      if (bus.rd_eop === 1'b1) eop_cnt++;
    end else begin
      if (exp_q.size() != 0 || bus.rd_sop !== 1'b0 || bus.rd_eop !== 1'b0 || bus.rd_data !== last_data) begin
        errors++;
        $display("FAIL idle_outputs pending=%0d sop=%b eop=%b data=%h exp data=%h",
                 exp_q.size(), bus.rd_sop, bus.rd_eop, bus.rd_data, last_data);
        exp_q.delete();
      end
    end
    if (bus.error === 1'b1) err_cnt++;
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) cycle();
  endtask

  task automatic do_reset();
    rst       = 1'b1;
    last_data = 16'h0;
    cycle();
    cycle();
    rst = 1'b0;
    exp_q.delete();
    ord_q.delete();
    for (int i = 0; i < N; i++) voq[i].delete();
  endtask

  task automatic test_reset();
    for (int i = 0; i < 2; i++) begin
      cycle();
      checks++;
      if ({bus.rd_en, bus.rd_sel, bus.rd_sop, bus.rd_eop, bus.rd_vld, bus.rd_data, bus.busy, bus.error} !== 24'd0) begin
        errors++;
        $display("FAIL reset_outputs got=%h exp=0", {bus.rd_en, bus.rd_sel, bus.rd_sop, bus.rd_eop,
                 bus.rd_vld, bus.rd_data, bus.busy, bus.error});
      end
    end
    rst = 1'b0;
    load_pkt(1, 3, 1'b1);
    ord_q.push_back(1);
    run(6);
    load_pkt(2, 3, 1'b1);
    ord_q.push_back(2);
    run(3);
    checks++;
    if (bus.busy !== 1'b1) begin
      errors++;
      $display("FAIL busy_mid_packet got=%b exp=1", bus.busy);
    end
    rst       = 1'b1;
    last_data = 16'h0;
    for (int i = 0; i < 2; i++) begin
      cycle();
      checks++;
      if ({bus.rd_en, bus.rd_sel, bus.rd_sop, bus.rd_eop, bus.rd_vld, bus.rd_data, bus.busy, bus.error} !== 24'd0) begin
        errors++;
        $display("FAIL midxfer_reset_outputs got=%h exp=0", {bus.rd_en, bus.rd_sel, bus.rd_sop, bus.rd_eop,
                 bus.rd_vld, bus.rd_data, bus.busy, bus.error});
      end
    end
    rst = 1'b0;
    voq[2].delete();
    load_pkt(0, 2, 1'b1);
    load_pkt(2, 2, 1'b1);
    ord_q.push_back(0);
    ord_q.push_back(2);
    run(8);
    checks++;
    if (ord_q.size() != 0 || exp_q.size() != 0) begin
      errors++;
      $display("FAIL reset_rr_restart left_grants=%0d left_words=%0d exp=0", ord_q.size(), exp_q.size());
    end
  endtask

  task automatic test_round_robin();
    int prev_eop;
    int e0;
    do_reset();
    bus.qos_mode = 1'b0;
    for (int v = 0; v < N; v++) begin
      load_pkt(v, 3, 1'b1);
      ord_q.push_back(v);
    end
    prev_eop = -1;
    e0 = eop_cnt;
    for (int i = 0; i < 20; i++) begin
      cycle();
      if (bus.rd_vld === 1'b1 && bus.rd_sop === 1'b1 && prev_eop >= 0) begin
        checks++;
        if (cyc - prev_eop != 2) begin
          errors++;
          $display("FAIL rr_packet_gap got=%0d exp=2", cyc - prev_eop);
        end
      end
      if (bus.rd_vld === 1'b1 && bus.rd_eop === 1'b1) prev_eop = cyc;
    end
    checks++;
    if (ord_q.size() != 0 || eop_cnt - e0 != 4) begin
      errors++;
      $display("FAIL rr_complete left_grants=%0d eops=%0d exp 0 and 4", ord_q.size(), eop_cnt - e0);
    end
  endtask

  task automatic test_strict_priority();
    int refills;
    bus.qos_mode = 1'b1;
    load_pkt(2, 2, 1'b1);
    load_pkt(0, 2, 1'b1);
    ord_q.push_back(0);
    ord_q.push_back(0);
    ord_q.push_back(0);
    ord_q.push_back(2);
    refills = 0;
    for (int i = 0; i < 20; i++) begin
      cycle();
      if (bus.rd_vld === 1'b1 && bus.rd_eop === 1'b1 && refills < 2 && voq[0].size() == 0) begin
        load_pkt(0, 2, 1'b1);
        refills++;
      end
    end
    checks++;
    if (ord_q.size() != 0 || exp_q.size() != 0) begin
      errors++;
      $display("FAIL strict_complete left_grants=%0d left_words=%0d exp=0", ord_q.size(), exp_q.size());
    end
    bus.qos_mode = 1'b0;
  endtask

  task automatic test_backpressure();
    int v0;
    int e0;
    load_pkt(3, 4, 1'b1);
    ord_q.push_back(3);
    v0 = vld_cnt;
    e0 = err_cnt;
    for (int k = 0; k < 12; k++) begin
      bus.ready = !(k >= 2 && k <= 4);
      cycle();
      if (k >= 2 && k <= 4) begin
        checks++;
        if (pop_en !== 1'b0) begin
          errors++;
          $display("FAIL bp_rd_en cycle=%0d got=%b exp=0", k, pop_en);
        end
      end
    end
    bus.ready = 1'b1;
    checks++;
    if (vld_cnt - v0 != 4 || err_cnt != e0 || exp_q.size() != 0) begin
      errors++;
      $display("FAIL bp_words got=%0d errs=%0d exp 4 and 0", vld_cnt - v0, err_cnt - e0);
    end
  endtask

  task automatic test_stall_abort();
    int stalls;
    int e0;
    int eo;
    load_pkt(1, 2, 1'b0);
    ord_q.push_back(1);
    stalls = 0;
    e0 = err_cnt;
    eo = eop_cnt;
    for (int i = 0; i < 12; i++) begin
      cycle();
      if (busy_pre === 1'b1 && pop_en === 1'b0) stalls++;
      if (bus.error === 1'b1) begin
        checks++;
        if (bus.busy !== 1'b0) begin
          errors++;
          $display("FAIL abort_busy got=%b exp=0", bus.busy);
        end
      end
    end
    checks++;
    if (stalls != 4) begin
      errors++;
      $display("FAIL stall_cycles got=%0d exp=4", stalls);
    end
    checks++;
    if (err_cnt - e0 != 1 || eop_cnt != eo) begin
      errors++;
      $display("FAIL abort_pulse errs=%0d eops=%0d exp 1 and 0", err_cnt - e0, eop_cnt - eo);
    end
  endtask

  task automatic test_single_word();
    int v0;
    load_pkt(3, 1, 1'b1);
    ord_q.push_back(3);
    v0 = vld_cnt;
    run(4);
    checks++;
    if (vld_cnt - v0 != 1) begin
      errors++;
      $display("FAIL single_word_count got=%0d exp=1", vld_cnt - v0);
    end
    load_pkt(2, 2, 1'b1);
    load_pkt(0, 2, 1'b1);
    ord_q.push_back(0);
    ord_q.push_back(2);
    run(8);
    checks++;
    if (ord_q.size() != 0 || exp_q.size() != 0) begin
      errors++;
      $display("FAIL rr_wrap left_grants=%0d left_words=%0d exp=0", ord_q.size(), exp_q.size());
    end
  endtask

  initial begin
    bus.empty       = 4'hF;
    bus.data_in     = 16'h0;
    bus.data_eop_in = 1'b0;
    bus.qos_mode    = 1'b0;
    bus.ready       = 1'b1;
    @(negedge clk);
    test_reset();
    test_round_robin();
    test_strict_priority();
    test_backpressure();
    test_stall_abort();
    test_single_word();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
